mem_port_arbiter: RTL and testbench

Sequential arbiter that shares one single-ported, fixed-latency unified memory between the pipeline's instruction-fetch stage and its MEM-stage load/store path. It sits between the PC/IF stage, the EX/MEM-to-MEM/WB boundary and the memory macro. It serialises accesses and returns read data with one-cycle completion pulses. It drives the stall lines that freeze PC, IF/ID or the whole pipeline while an access is outstanding.

---
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, fixed-latency memory between instruction fetch and
// the MEM-stage load/store path, with a bounded wait for starved fetches.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LAT_W    = $clog2(MEM_LAT + 1);
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                we_q, we_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                if_valid_q, if_valid_d;
  logic                dm_done_q, dm_done_d;

  logic dm_req;
  logic starve_full;
  logic grant_data;
  logic grant_fetch;

  assign dm_req      = dm_read | dm_write;
  assign starve_full = (starve_cnt_q == STARVE_W'(STARVE_MAX));
  assign grant_data  = dm_req & ~(starve_full & if_req);
  assign grant_fetch = ~grant_data & if_req;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    we_d         = we_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_valid_d   = 1'b0;
    dm_done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_data) begin
          owner_d     = OWN_D;
          we_d        = dm_write;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_write;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          state_d     = ISSUE;
          // Only a data grant that overtakes a waiting fetch counts toward starvation.
          if (!if_req) begin
            starve_cnt_d = '0;
          end else if (!starve_full) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
          end
        end else if (grant_fetch) begin
          owner_d      = OWN_I;
          we_d         = 1'b0;
          mem_en_d     = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          state_d      = ISSUE;
          starve_cnt_d = '0;
        end else begin
          starve_cnt_d = '0;
        end
      end
      ISSUE: begin
        lat_cnt_d = LAT_W'(MEM_LAT);
        state_d   = WAIT;
      end
      WAIT: begin
        lat_cnt_d = lat_cnt_q - LAT_W'(1);
        if (lat_cnt_q == LAT_W'(1)) begin
          state_d = IDLE;
          if (owner_q == OWN_I) begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end else begin
            if (!we_q) begin
              dm_rdata_d = mem_rdata;
            end
            dm_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      we_q         <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_valid_q   <= 1'b0;
      dm_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      we_q         <= we_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_valid_q   <= if_valid_d;
      dm_done_q    <= dm_done_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_done   = dm_done_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Stalls release in the same cycle as the matching completion pulse.
  assign stall_mem = dm_req & ~dm_done_q;
  assign stall_if  = (if_req & ~if_valid_q) | stall_mem;

  a_done_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(if_valid_q && dm_done_q));

  a_en_only_in_issue: assert property (@(posedge clk) disable iff (reset)
    mem_en_q |-> (state_q == ISSUE));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts
// issue and completion cycles, a separate monitor checks them every cycle.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              dm_read;
  logic              dm_write;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_done;
  logic              stall_if;
  logic              stall_mem;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } issue_t;

  typedef struct {
    int          cyc;
    logic        is_data;
    logic [31:0] rdata;
  } done_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rsp_t;

  issue_t issue_q[$];
  done_t  done_q[$];
  rsp_t   rsp_q[$];

  int cyc    = 0;
  int checks = 0;
  int passes = 0;
  bit armed  = 1'b0;

  function automatic logic [31:0] memModel(input logic [31:0] addr);
    return (addr * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: actual=%h required=%h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic ifr, input logic [31:0] ifa,
                               input logic dr, input logic dw, input logic [31:0] da,
                               input logic [31:0] dwd);
    reset    = rst;
    if_req   = ifr;
    if_addr  = ifa;
    dm_read  = dr;
    dm_write = dw;
    dm_addr  = da;
    dm_wdata = dwd;
    stepCycle();
  endtask

  // Hold the chosen request until its completion pulse, then drop it in that cycle.
  task automatic waitFor(input bit for_fetch, input int bound);
    int n = 0;
    while (!(for_fetch ? if_valid : dm_done) && n < bound) begin
      stepCycle();
      n++;
    end
    if (for_fetch) begin
      checkOutput("wait_if_valid", {31'b0, if_valid}, 32'd1);
      if_req = 1'b0;
    end else begin
      checkOutput("wait_dm_done", {31'b0, dm_done}, 32'd1);
      dm_read  = 1'b0;
      dm_write = 1'b0;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_if_rdata"}, if_rdata, 32'd0);
    checkOutput({tag, "_dm_rdata"}, dm_rdata, 32'd0);
    checkOutput({tag, "_if_valid"}, {31'b0, if_valid}, 32'd0);
    checkOutput({tag, "_dm_done"}, {31'b0, dm_done}, 32'd0);
    checkOutput({tag, "_mem_en"}, {31'b0, mem_en}, 32'd0);
    checkOutput({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    checkOutput({tag, "_stall_if"}, {31'b0, stall_if}, 32'd0);
    checkOutput({tag, "_stall_mem"}, {31'b0, stall_mem}, 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc <= cyc + 1;
    end
  end

  // Memory macro: answers each strobe exactly MEM_LAT cycles later, noise otherwise.
  initial begin
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_en === 1'b1) rsp_q.push_back('{cyc + MEM_LAT, memModel(mem_addr)});
      #1;
      while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) void'(rsp_q.pop_front());
      if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
        mem_rdata = rsp_q[0].data;
        void'(rsp_q.pop_front());
      end else begin
        mem_rdata = $urandom;
      end
    end
  end

  // Reference model: the memory is free again MEM_LAT+2 cycles after each decision.
  initial begin
    int          free_at;
    int          starve;
    logic [31:0] last_dm;
    bit          take_d;
    free_at = 0;
    starve  = 0;
    last_dm = '0;
    forever begin
      @(posedge clk);
      if (reset === 1'b1) begin
        issue_q.delete();
        done_q.delete();
        free_at = cyc + 1;
        starve  = 0;
        last_dm = '0;
      end else if (armed && cyc >= free_at) begin
        take_d = (dm_read || dm_write) && !(if_req && starve == STARVE_MAX);
        if (take_d) begin
          starve = if_req ? ((starve < STARVE_MAX) ? starve + 1 : starve) : 0;
          if (!dm_write) last_dm = memModel(dm_addr);
          issue_q.push_back('{cyc + 1, dm_addr, dm_write, dm_wdata});
          done_q.push_back('{cyc + 2 + MEM_LAT, 1'b1, last_dm});
          free_at = cyc + 2 + MEM_LAT;
        end else if (if_req) begin
          starve = 0;
          issue_q.push_back('{cyc + 1, if_addr, 1'b0, 32'd0});
          done_q.push_back('{cyc + 2 + MEM_LAT, 1'b0, memModel(if_addr)});
          free_at = cyc + 2 + MEM_LAT;
        end else begin
          starve = 0;
        end
      end
    end
  end

  initial begin
    issue_t it;
    done_t  dn;
    bit     exp_if_v;
    bit     exp_dm_d;
    forever begin
      @(negedge clk);
      if (armed) begin
        exp_if_v = 1'b0;
        exp_dm_d = 1'b0;
        if (issue_q.size() > 0 && issue_q[0].cyc == cyc) begin
          it = issue_q.pop_front();
          checkOutput("issue_mem_en", {31'b0, mem_en}, 32'd1);
          checkOutput("issue_mem_addr", mem_addr, it.addr);
          checkOutput("issue_mem_we", {31'b0, mem_we}, {31'b0, it.we});
          if (it.we) checkOutput("issue_mem_wdata", mem_wdata, it.wdata);
        end else begin
          checkOutput("quiet_mem_en", {31'b0, mem_en}, 32'd0);
          checkOutput("quiet_mem_we", {31'b0, mem_we}, 32'd0);
        end
        if (done_q.size() > 0 && done_q[0].cyc == cyc) begin
          dn = done_q.pop_front();
          exp_if_v = !dn.is_data;
          exp_dm_d = dn.is_data;
          if (dn.is_data) checkOutput("dm_rdata", dm_rdata, dn.rdata);
          else            checkOutput("if_rdata", if_rdata, dn.rdata);
        end
        checkOutput("if_valid", {31'b0, if_valid}, {31'b0, exp_if_v});
        checkOutput("dm_done", {31'b0, dm_done}, {31'b0, exp_dm_d});
        checkOutput("stall_mem", {31'b0, stall_mem},
                    {31'b0, (dm_read | dm_write) & !exp_dm_d});
        checkOutput("stall_if", {31'b0, stall_if},
                    {31'b0, (if_req & !exp_if_v) | ((dm_read | dm_write) & !exp_dm_d)});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    reset    = 1'b1;
    if_req   = 1'b0;
    if_addr  = '0;
    dm_read  = 1'b0;
    dm_write = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    stepCycle();
    stepCycle();
    armed = 1'b1;
    checkAllZero("reset");
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] fetch only");
    applyStimulus(0, 1, 32'h40, 0, 0, 0, 0);
    waitFor(1'b1, 20);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] fetch/load conflict");
    applyStimulus(0, 1, 32'h44, 1, 0, 32'h100, 0);
    waitFor(1'b0, 20);
    waitFor(1'b1, 20);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] store");
    applyStimulus(0, 0, 0, 0, 1, 32'h200, 32'hDEADBEEF);
    waitFor(1'b0, 20);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] read and write together");
    applyStimulus(0, 0, 0, 1, 1, 32'h204, 32'h12345678);
    waitFor(1'b0, 20);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] starvation");
    applyStimulus(0, 1, 32'h80, 1, 0, 32'h300, 0);
    for (int i = 0; i < 40; i++) begin
      if (dm_done) dm_addr = dm_addr + 32'd4;
      if (if_valid) if_addr = if_addr + 32'd4;
      stepCycle();
    end
    if_req  = 1'b0;
    dm_read = 1'b0;
    repeat (10) stepCycle();

    $display("[TB] reset during WAIT");
    applyStimulus(0, 0, 0, 1, 0, 32'h104, 0);
    waitFor(1'b0, 20);
    applyStimulus(0, 0, 0, 1, 0, 32'h108, 0);
    stepCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkAllZero("midreset");
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    repeat (8) stepCycle();

    $display("[TB] dropped request");
    applyStimulus(0, 1, 32'h500, 0, 0, 0, 0);
    stepCycle();
    applyStimulus(0, 1, 32'h500, 1, 0, 32'h600, 0);
    applyStimulus(0, 1, 32'h500, 0, 0, 0, 0);
    waitFor(1'b1, 20);
    repeat (8) stepCycle();

    $display("[TB] random traffic");
    for (int i = 0; i < 500; i++) begin
      if (if_valid) if_req = 1'b0;
      if (dm_done) begin
        dm_read  = 1'b0;
        dm_write = 1'b0;
      end
      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req  = 1'b1;
        if_addr = $urandom & 32'h0000_FFFC;
      end
      if (!(dm_read || dm_write) && $urandom_range(0, 2) == 0) begin
        int kind;
        kind     = $urandom_range(0, 3);
        dm_read  = (kind != 2);
        dm_write = (kind >= 2);
        dm_addr  = $urandom & 32'h0000_FFFC;
        dm_wdata = $urandom;
      end else if ((dm_read || dm_write) && $urandom_range(0, 31) == 0) begin
        dm_read  = 1'b0;
        dm_write = 1'b0;
      end
      stepCycle();
    end
    if_req   = 1'b0;
    dm_read  = 1'b0;
    dm_write = 1'b0;
    repeat (12) stepCycle();

    checkOutput("drain_issue_q", issue_q.size(), 32'd0);
    checkOutput("drain_done_q", done_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
